// File: rtl/video_timing_pkg.sv
// Shared 720p60 raster timing constants and the flag bundle
// carried alongside pixels by downstream delay lines.
package video_timing_pkg;

    localparam int DEF_ACTIVE_H_PIXELS = 1280;
    localparam int DEF_H_FRONT_PORCH   = 110;
    localparam int DEF_H_SYNC_WIDTH    = 40;
    localparam int DEF_H_BACK_PORCH    = 220;
    localparam int DEF_ACTIVE_LINES    = 720;
    localparam int DEF_V_FRONT_PORCH   = 5;
    localparam int DEF_V_SYNC_WIDTH    = 5;
    localparam int DEF_V_BACK_PORCH    = 20;
    localparam int DEF_FPS             = 60;

    localparam int TOTAL_PIXELS = DEF_ACTIVE_H_PIXELS
                                + DEF_H_FRONT_PORCH
                                + DEF_H_SYNC_WIDTH
                                + DEF_H_BACK_PORCH;
    localparam int TOTAL_LINES  = DEF_ACTIVE_LINES
                                + DEF_V_FRONT_PORCH
                                + DEF_V_SYNC_WIDTH
                                + DEF_V_BACK_PORCH;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;
    localparam int FC_W     = 6;

    typedef struct packed {
        logic hs;
        logic vs;
        logic ad;
        logic nf;
    } vid_flags_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with enable; wrap_out flags the increment
// that returns the count to zero so counters can be chained.
module mod_counter #(
    parameter int MODULUS = 2,
    parameter int WIDTH   = $clog2(MODULUS)
) (
    input  logic             pixel_clk_in,
    input  logic             rst_in,
    input  logic             inc_in,
    output logic [WIDTH-1:0] count_out,
    output logic             wrap_out
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;

    assign wrap_out  = inc_in && (r_count == LAST);
    assign count_out = r_count;

    // Count on enable, fold back to zero after the last value
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_count <= '0;
        end else if (wrap_out) begin
            r_count <= '0;
        end else if (inc_in) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/video_sig_gen.sv
// Raster timing generator: pixel/line/frame counters plus
// zero-skew sync, active-draw and new-frame decodes.
module video_sig_gen
    import video_timing_pkg::*;
#(
    parameter int ACTIVE_H_PIXELS = DEF_ACTIVE_H_PIXELS,
    parameter int H_FRONT_PORCH   = DEF_H_FRONT_PORCH,
    parameter int H_SYNC_WIDTH    = DEF_H_SYNC_WIDTH,
    parameter int H_BACK_PORCH    = DEF_H_BACK_PORCH,
    parameter int ACTIVE_LINES    = DEF_ACTIVE_LINES,
    parameter int V_FRONT_PORCH   = DEF_V_FRONT_PORCH,
    parameter int V_SYNC_WIDTH    = DEF_V_SYNC_WIDTH,
    parameter int V_BACK_PORCH    = DEF_V_BACK_PORCH,
    parameter int FPS             = DEF_FPS
) (
    input  logic                pixel_clk_in,
    input  logic                rst_in,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [VCOUNT_W-1:0] vcount_out,
    output logic                hs_out,
    output logic                vs_out,
    output logic                ad_out,
    output logic                nf_out,
    output logic [FC_W-1:0]     fc_out
);

    localparam int H_TOTAL = ACTIVE_H_PIXELS + H_FRONT_PORCH
                           + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int V_TOTAL = ACTIVE_LINES + V_FRONT_PORCH
                           + V_SYNC_WIDTH + V_BACK_PORCH;

    // 12-bit compare constants keep the sync end point from
    // overflowing the 11-bit pixel index.
    localparam logic [11:0] C_AH  = 12'(ACTIVE_H_PIXELS);
    localparam logic [11:0] C_AL  = 12'(ACTIVE_LINES);
    localparam logic [11:0] C_NFH = 12'(ACTIVE_H_PIXELS - 1);
    localparam logic [11:0] C_HS0 =
        12'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
    localparam logic [11:0] C_HS1 =
        12'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [11:0] C_VS0 =
        12'(ACTIVE_LINES + V_FRONT_PORCH);
    localparam logic [11:0] C_VS1 =
        12'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH);

    if (H_TOTAL > 2048 || V_TOTAL > 1024 || FPS > 64) begin : g_bad
        $error("video_sig_gen: raster exceeds counter widths");
    end

    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_f_wrap;
    logic        w_nf_entry;
    logic [11:0] w_h12;
    logic [11:0] w_v12;
    vid_flags_t  w_flags;

    mod_counter #(.MODULUS(H_TOTAL), .WIDTH(HCOUNT_W)) u_pix (
        .pixel_clk_in (pixel_clk_in),
        .rst_in       (rst_in),
        .inc_in       (1'b1),
        .count_out    (hcount_out),
        .wrap_out     (w_h_wrap)
    );

    mod_counter #(.MODULUS(V_TOTAL), .WIDTH(VCOUNT_W)) u_line (
        .pixel_clk_in (pixel_clk_in),
        .rst_in       (rst_in),
        .inc_in       (w_h_wrap),
        .count_out    (vcount_out),
        .wrap_out     (w_v_wrap)
    );

    mod_counter #(.MODULUS(FPS), .WIDTH(FC_W)) u_frame (
        .pixel_clk_in (pixel_clk_in),
        .rst_in       (rst_in),
        .inc_in       (w_nf_entry),
        .count_out    (fc_out),
        .wrap_out     (w_f_wrap)
    );

    assign w_h12 = 12'(hcount_out);
    assign w_v12 = 12'(vcount_out);

    // Frame count advances on the edge that lands on the nf pixel
    assign w_nf_entry = (w_h12 == C_NFH) && (w_v12 == C_AL);

    wire w_unused_wraps = w_v_wrap ^ w_f_wrap;

    // Decode flags from the live counters, blanked during reset
    always_comb begin
        w_flags = '0;
        if (!rst_in) begin
            w_flags.ad = (w_h12 < C_AH) && (w_v12 < C_AL);
            w_flags.hs = (w_h12 >= C_HS0) && (w_h12 < C_HS1);
            w_flags.vs = (w_v12 >= C_VS0) && (w_v12 < C_VS1);
            w_flags.nf = (w_h12 == C_AH) && (w_v12 == C_AL);
        end
    end

    assign hs_out = w_flags.hs;
    assign vs_out = w_flags.vs;
    assign ad_out = w_flags.ad;
    assign nf_out = w_flags.nf;

endmodule

// File: tb/tb_video_sig_gen.sv
// Self-checking bench: scoreboarded reduced raster plus a
// single-line sweep of the default 720p instance.
module tb_video_sig_gen;

    localparam int AH  = 16;
    localparam int HFP = 3;
    localparam int HSW = 4;
    localparam int HBP = 5;
    localparam int AL  = 8;
    localparam int VFP = 2;
    localparam int VSW = 2;
    localparam int VBP = 3;
    localparam int FPS = 60;
    localparam int TP  = AH + HFP + HSW + HBP;
    localparam int TL  = AL + VFP + VSW + VBP;
    localparam int FRAME = TP * TL;

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        ad;
        logic        nf;
        logic [5:0]  fc;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s  = 1'b1;
    logic rst_hd = 1'b1;

    logic [10:0] hcount_s, hcount_hd;
    logic [9:0]  vcount_s, vcount_hd;
    logic        hs_s, vs_s, ad_s, nf_s;
    logic        hs_hd, vs_hd, ad_hd, nf_hd;
    logic [5:0]  fc_s, fc_hd;

    video_sig_gen #(
        .ACTIVE_H_PIXELS (AH),
        .H_FRONT_PORCH   (HFP),
        .H_SYNC_WIDTH    (HSW),
        .H_BACK_PORCH    (HBP),
        .ACTIVE_LINES    (AL),
        .V_FRONT_PORCH   (VFP),
        .V_SYNC_WIDTH    (VSW),
        .V_BACK_PORCH    (VBP),
        .FPS             (FPS)
    ) dut (
        .pixel_clk_in (clk),
        .rst_in       (rst_s),
        .hcount_out   (hcount_s),
        .vcount_out   (vcount_s),
        .hs_out       (hs_s),
        .vs_out       (vs_s),
        .ad_out       (ad_s),
        .nf_out       (nf_s),
        .fc_out       (fc_s)
    );

    video_sig_gen dut_hd (
        .pixel_clk_in (clk),
        .rst_in       (rst_hd),
        .hcount_out   (hcount_hd),
        .vcount_out   (vcount_hd),
        .hs_out       (hs_hd),
        .vs_out       (vs_hd),
        .ad_out       (ad_hd),
        .nf_out       (nf_hd),
        .fc_out       (fc_hd)
    );

    int   checks   = 0;
    int   failures = 0;
    obs_t exp_q[$];
    obs_t g;
    int   m_h  = 0;
    int   m_v  = 0;
    int   m_fc = 0;
    bit   inv_on = 1'b0;

    function automatic obs_t sample_s();
        return {hcount_s, vcount_s, hs_s, vs_s, ad_s, nf_s, fc_s};
    endfunction

    function automatic obs_t sample_hd();
        return {hcount_hd, vcount_hd, hs_hd, vs_hd, ad_hd, nf_hd,
                fc_hd};
    endfunction

    // One clock of the reduced raster: advance model, queue the
    // expectation, compare at mid-cycle.
    task automatic cyc(input logic r);
        obs_t e;
        logic smp;
        @(posedge clk);
        smp = rst_s;
        if (smp) begin
            m_h = 0; m_v = 0; m_fc = 0;
        end else begin
            if (m_h == AH - 1 && m_v == AL)
                m_fc = (m_fc == FPS - 1) ? 0 : m_fc + 1;
            if (m_h == TP - 1) begin
                m_h = 0;
                m_v = (m_v == TL - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
        #1 rst_s = r;
        e.h  = 11'(m_h);
        e.v  = 10'(m_v);
        e.fc = 6'(m_fc);
        e.ad = !r && (m_h < AH) && (m_v < AL);
        e.hs = !r && (m_h >= AH + HFP) && (m_h < AH + HFP + HSW);
        e.vs = !r && (m_v >= AL + VFP) && (m_v < AL + VFP + VSW);
        e.nf = !r && (m_h == AH) && (m_v == AL);
        exp_q.push_back(e);
        @(negedge clk);
        g = sample_s();
        e = exp_q.pop_front();
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL scoreboard got=%h exp=%h (h=%0d v=%0d)",
                     g, e, m_h, m_v);
        end
    endtask

    always @(negedge clk) begin
        if (inv_on) begin
            checks++;
            if (ad_s && (hcount_s >= AH || vcount_s >= AL)) begin
                failures++;
                $display("FAIL inv_ad_blank got ad=1 at h=%0d v=%0d req ad=0",
                         hcount_s, vcount_s);
            end
            checks++;
            if (ad_s && hs_s) begin
                failures++;
                $display("FAIL inv_ad_hs got both high at h=%0d req exclusive",
                         hcount_s);
            end
        end
    end

    task automatic test_reset();
        repeat (5) cyc(1'b1);
        checks++;
        if (g !== '0) begin
            failures++;
            $display("FAIL reset_zero got=%h req=0", g);
        end
        inv_on = 1'b1;
        cyc(1'b0);
        checks++;
        if (g.h !== 0 || g.v !== 0 || g.ad !== 1'b1) begin
            failures++;
            $display("FAIL release_c1 got h=%0d v=%0d ad=%b req 0,0,1",
                     g.h, g.v, g.ad);
        end
        cyc(1'b0);
        checks++;
        if (g.h !== 11'd1) begin
            failures++;
            $display("FAIL release_c2 got h=%0d req 1", g.h);
        end
    endtask

    task automatic test_line();
        int   hs_cnt = 0, hs_first = -1, hs_last = -1, ad_fall = -1;
        bit   wrapped = 0;
        obs_t p;
        p = g;
        for (int i = 0; i < TP + 2 && !wrapped; i++) begin
            p = g;
            cyc(1'b0);
            if (p.ad && !g.ad && ad_fall < 0) ad_fall = int'(g.h);
            if (g.hs) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(g.h);
                hs_last = int'(g.h);
            end
            if (g.h == 0) wrapped = 1;
        end
        checks++;
        if (!wrapped) begin
            failures++;
            $display("FAIL line_timeout got no wrap req wrap");
        end
        checks++;
        if (ad_fall != AH) begin
            failures++;
            $display("FAIL ad_fall got %0d req %0d", ad_fall, AH);
        end
        checks++;
        if (hs_cnt != HSW || hs_first != AH + HFP ||
            hs_last != AH + HFP + HSW - 1) begin
            failures++;
            $display("FAIL hs_window got n=%0d %0d..%0d req n=%0d %0d..%0d",
                     hs_cnt, hs_first, hs_last, HSW, AH + HFP,
                     AH + HFP + HSW - 1);
        end
        checks++;
        if (p.h !== 11'(TP - 1) || g.v !== 10'd1) begin
            failures++;
            $display("FAIL line_wrap got prev_h=%0d v=%0d req %0d,1",
                     p.h, g.v, TP - 1);
        end
    endtask

    task automatic test_frame();
        int   n = 0, vs_cnt = 0, vs_min = 999, vs_max = -1;
        bit   got_nf = 0, vwrap = 0;
        obs_t p;
        for (int i = 0; i < 2 * FRAME && !g.nf; i++) cyc(1'b0);
        checks++;
        if (!g.nf || g.h !== 11'(AH) || g.v !== 10'(AL)) begin
            failures++;
            $display("FAIL nf_pos got nf=%b h=%0d v=%0d req 1,%0d,%0d",
                     g.nf, g.h, g.v, AH, AL);
        end
        for (int i = 0; i < FRAME + 5 && !got_nf; i++) begin
            p = g;
            cyc(1'b0);
            n++;
            if (g.vs) begin
                vs_cnt++;
                if (int'(g.v) < vs_min) vs_min = int'(g.v);
                if (int'(g.v) > vs_max) vs_max = int'(g.v);
            end
            if (p.v == 10'(TL - 1) && g.v == 0) vwrap = 1;
            if (g.nf) got_nf = 1;
        end
        checks++;
        if (n != FRAME) begin
            failures++;
            $display("FAIL frame_len got %0d req %0d", n, FRAME);
        end
        checks++;
        if (vs_cnt != VSW * TP || vs_min != AL + VFP ||
            vs_max != AL + VFP + VSW - 1) begin
            failures++;
            $display("FAIL vs_window got n=%0d %0d..%0d req n=%0d %0d..%0d",
                     vs_cnt, vs_min, vs_max, VSW * TP, AL + VFP,
                     AL + VFP + VSW - 1);
        end
        checks++;
        if (!vwrap) begin
            failures++;
            $display("FAIL v_wrap got none req %0d->0", TL - 1);
        end
    endtask

    task automatic test_frame_counter();
        int   changes = 0, bad = 0;
        bit   wrapped = 0;
        obs_t p;
        for (int i = 0; i < 61 * FRAME; i++) begin
            p = g;
            cyc(1'b0);
            if (g.fc != p.fc) begin
                changes++;
                if (!g.nf) bad++;
                if (p.fc == 6'(FPS - 1) && g.fc == 0) wrapped = 1;
            end else if (g.nf) begin
                bad++;
            end
        end
        checks++;
        if (changes != 61) begin
            failures++;
            $display("FAIL fc_changes got %0d req 61", changes);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL fc_nf_align got %0d misaligned req 0", bad);
        end
        checks++;
        if (!wrapped) begin
            failures++;
            $display("FAIL fc_wrap got none req %0d->0", FPS - 1);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        for (int i = 0; i < FRAME + 2 &&
             !(g.h == 11'd10 && g.v == 10'd5); i++) cyc(1'b0);
        cyc(1'b1);
        checks++;
        if (g.hs || g.vs || g.ad || g.nf) begin
            failures++;
            $display("FAIL midrst_flags got %b%b%b%b req 0000",
                     g.hs, g.vs, g.ad, g.nf);
        end
        cyc(1'b0);
        checks++;
        if (g.h !== 0 || g.v !== 0 || g.fc !== 0 || g.ad !== 1'b1) begin
            failures++;
            $display("FAIL midrst_restart got h=%0d v=%0d fc=%0d req 0,0,0",
                     g.h, g.v, g.fc);
        end
        for (int i = 0; i < FRAME && !g.nf; i++) begin
            cyc(1'b0);
            n++;
        end
        checks++;
        if (n != AL * TP + AH || g.h !== 11'(AH) || g.v !== 10'(AL) ||
            g.fc !== 6'd1) begin
            failures++;
            $display("FAIL midrst_nf got n=%0d h=%0d v=%0d fc=%0d req %0d,%0d,%0d,1",
                     n, g.h, g.v, g.fc, AL * TP + AH, AH, AL);
        end
    endtask

    task automatic test_hd_line();
        obs_t e, o;
        int   hs_cnt = 0, h;
        o = sample_hd();
        checks++;
        if (o !== '0) begin
            failures++;
            $display("FAIL hd_reset got=%h req=0", o);
        end
        @(posedge clk);
        #1 rst_hd = 1'b0;
        for (int i = 0; i <= 1650; i++) begin
            if (i > 0) @(posedge clk);
            h = i % 1650;
            e = '0;
            e.h  = 11'(h);
            e.v  = 10'(i / 1650);
            e.hs = (h >= 1390) && (h < 1430);
            e.ad = (h < 1280);
            exp_q.push_back(e);
            @(negedge clk);
            o = sample_hd();
            e = exp_q.pop_front();
            if (o.hs) hs_cnt++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL hd_scoreboard got=%h exp=%h i=%0d",
                         o, e, i);
            end
        end
        checks++;
        if (hs_cnt != 40) begin
            failures++;
            $display("FAIL hd_hs_len got %0d req 40", hs_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_frame_counter();
        test_mid_reset();
        test_hd_line();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
